// File: rtl/alu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_queue
// Description : In-order writeback FIFO between the ALU and the register-file
//               write port; retires NZCV into the architectural flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_queue #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]         in_result,
    input  logic [3:0]                in_flags,
    input  logic                      in_flag_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_W-1:0]          out_rd,
    output logic [DATA_W-1:0]         out_result,
    output logic [3:0]                out_flags,
    output logic [3:0]                flags_q,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [REG_W-1:0]  rd_mem_q  [DEPTH];
    logic [DATA_W-1:0] res_mem_q [DEPTH];
    logic [3:0]        flg_mem_q [DEPTH];
    logic              fwe_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        flags_d;
    logic              w_push;
    logic              w_pop;

    // in_ready depends only on occupancy, so a pop while full cannot admit a push
    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (fwe_mem_q[rd_ptr_q]) begin
                flags_d = flg_mem_q[rd_ptr_q];
            end
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= 4'b0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    // Entry storage is deliberately left unreset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            rd_mem_q[wr_ptr_q]  <= in_rd;
            res_mem_q[wr_ptr_q] <= in_result;
            flg_mem_q[wr_ptr_q] <= in_flags;
            fwe_mem_q[wr_ptr_q] <= in_flag_we;
        end
    end

    always_comb begin
        out_rd     = '0;
        out_result = '0;
        out_flags  = 4'b0000;
        if (out_valid) begin
            out_rd     = rd_mem_q[rd_ptr_q];
            out_result = res_mem_q[rd_ptr_q];
            out_flags  = flg_mem_q[rd_ptr_q];
        end
    end

endmodule
`default_nettype wire
